seven_segment_capture: RTL
==========================

Name: seven_segment_capture

Overview:
Receive-side counterpart of the multiplexed 4-digit display driver. Samples the 11-bit {anode[3:0], segments[6:0]} scan bus and debounces each scanned digit. Decodes the active-low patterns back to BCD, reassembles a full MM:SS frame and presents binary minutes/seconds with a valid strobe. Used for display loopback self-check and as a bench monitor on the display bus.

Parameters:
STABLE_CYCLES, 16, consecutive cycles a bus value must stay unchanged before it is accepted (>=2)
TIMEOUT_CYCLES, 262144, cycles without a completed good frame before stale_o asserts

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
seg_i  input  11  scan bus {anode[3:0], seg[6:0]}; anode one-hot active-low, seg active-low abcdefg
min_o  output  6  last captured minutes, binary
sec_o  output  6  last captured seconds, binary
valid_o  output  1  1-cycle pulse when min_o/sec_o update
err_o  output  1  1-cycle pulse on any protocol/decode error
stale_o  output  1  high while no good frame for TIMEOUT_CYCLES
err_cnt_o  output  8  error count (see Optional Feature)

Behaviour:
- Reset: min_o=0, sec_o=0, valid_o=0, err_o=0, stale_o=0, err_cnt_o=0, FSM=IDLE, internal sample reg=11'h7FF, stability/timeout counters=0. Reset mid-frame discards partial digits.
- Stability filter: seg_i registered each cycle. Compare seg_i to the sample reg. Mismatch -> counter=0. Match -> counter increments, saturating.
  - Exactly one accept strobe per stable period, when the counter reaches STABLE_CYCLES-1.
  - Glitches shorter than STABLE_CYCLES produce no accept.
- Anode decode at accept:
  - 0111 -> pos0 (min tens), 1011 -> pos1 (min ones), 1101 -> pos2 (sec tens), 1110 -> pos3 (sec ones).
  - 1111 -> blank, ignored, no state change.
  - Any other value -> error.
- Segment decode:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - Any other value -> error.
- Frame FSM, states IDLE and COLLECT(expected pos 1..3):
  - IDLE: accept pos0 -> store digit, COLLECT(1). Accept of pos1-3 -> ignored, no error; this syncs to the frame start.
  - COLLECT(e), accept pos==e: store digit. If e<3 -> COLLECT(e+1). If e==3 -> frame complete -> IDLE.
  - COLLECT(e), accept pos==e-1 (same digit re-accepted after its value changed): overwrite stored digit, stay.
  - COLLECT(e), any other pos: error, discard frame. If pos==0, store digit and go to COLLECT(1); else go to IDLE.
- Frame complete: min = tens*10+ones, sec likewise; 7-bit intermediate.
  - If either result >63: error, outputs unchanged.
  - Otherwise min_o/sec_o load and valid_o pulses on the same edge, one cycle after the final accept.
  - Latency: valid_o rises STABLE_CYCLES+2 cycles after the pos3 value first appears on seg_i (held stable).
- Any error: err_o pulses one cycle, valid_o stays low, outputs hold previous values. Decode errors also abort the frame to IDLE.
- Timeout: counter clears on every valid_o and otherwise increments, saturating.
  - stale_o=1 when the count reaches TIMEOUT_CYCLES; cleared on the same edge valid_o pulses.
- Simultaneous frame-complete and range error: error wins, no valid_o.

Optional Feature:
SSD_CAPTURE_ERR_COUNT_EN
- Defined: err_cnt_o is an 8-bit counter, +1 per err_o pulse, saturating at 255, cleared only by rst.
- Undefined: err_cnt_o tied to 0 and no counter logic; all other behaviour identical.

Test Plan:
- STABLE_CYCLES=4. Drive 0111_1001111, 1011_0010010, 1101_0000110, 1110_1001100, each held 8 cycles -> single valid_o pulse, min_o=12, sec_o=34, err_o never high.
- Same frame with a 2-cycle glitch 1011_0000000 inserted mid-scan -> glitch ignored, result still 12/34, no err_o.
- Frame with pos1 seg=1111110 -> err_o pulse, no valid_o, min_o/sec_o keep 12/34; next clean frame 05/59 -> valid_o, 5/59.
- Scan order pos0, pos3 -> err_o pulse, frame aborted; following full frame 00/00 captured normally.
- Frame min tens=9, ones=9 (seg 0000100 twice) -> err_o pulse (99>63), outputs unchanged; frame 63/00 -> valid_o, min_o=63.
- TIMEOUT_CYCLES=64, bus held 1111_1111111 -> stale_o=1 after 64 cycles; assert rst mid-frame -> all outputs 0; next good frame clears stale_o.

Source files
------------

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: receive side of the multiplexed 4-digit MM:SS display.
// It debounces the {anode, segments} scan bus, decodes each digit back to BCD,
// rebuilds the full frame and presents binary minutes and seconds.
// Optional build macro: SSD_CAPTURE_ERR_COUNT_EN enables the saturating error counter.
module seven_segment_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] seg_i,
  output logic [5:0]  min_o,
  output logic [5:0]  sec_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        stale_o,
  output logic [7:0]  err_cnt_o
);

  localparam int SCW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  logic [10:0]    sample_q, sample_d;
  logic [SCW-1:0] stab_q, stab_d;
  logic           accept_q, accept_d;
  state_e         state_q, state_d;
  logic [1:0]     exp_q, exp_d;
  logic [3:0]     digit_q [4];
  logic [3:0]     digit_d [4];
  logic           done_q, done_d;
  logic [5:0]     min_q, min_d, sec_q, sec_d;
  logic           valid_q, valid_d, err_q, err_d;
  logic [TCW-1:0] tmo_q, tmo_d;

  logic [1:0] pos;
  logic       pos_ok, blank, dig_ok, frame_err, range_err;
  logic [3:0] dig;
  logic [6:0] min_calc, sec_calc;

  // Stability filter: one accept strobe when the bus has matched the sample for STABLE_CYCLES-1 edges.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    sample_d = seg_i;
    stab_d   = stab_q;
    accept_d = 1'b0;
    if (seg_i != sample_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + SCW'(1);
      if (stab_q == STAB_MAX - SCW'(1)) accept_d = 1'b1;
    end
  end

  // Anode and segment decode of the accepted bus value.
  always_comb begin
    pos    = 2'd0;
    pos_ok = 1'b1;
    blank  = 1'b0;
    case (sample_q[10:7])
      4'b0111: pos = 2'd0;
      4'b1011: pos = 2'd1;
      4'b1101: pos = 2'd2;
      4'b1110: pos = 2'd3;
      4'b1111: blank = 1'b1;
      default: pos_ok = 1'b0;
    endcase
    dig    = 4'd0;
    dig_ok = 1'b1;
    case (sample_q[6:0])
      7'b0000001: dig = 4'd0;
      7'b1001111: dig = 4'd1;
      7'b0010010: dig = 4'd2;
      7'b0000110: dig = 4'd3;
      7'b1001100: dig = 4'd4;
      7'b0100100: dig = 4'd5;
      7'b0100000: dig = 4'd6;
      7'b0001111: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0000100: dig = 4'd9;
      default:    dig_ok = 1'b0;
    endcase
  end

  // Frame FSM: collects positions 0..3 in order, tolerating re-accept of the previous digit.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    digit_d   = digit_q;
    done_d    = 1'b0;
    frame_err = 1'b0;
    if (accept_q && !blank) begin
      if (!pos_ok || !dig_ok) begin
        frame_err = 1'b1;
        state_d   = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (pos == 2'd0) begin
              digit_d[0] = dig;
              state_d    = S_COLLECT;
              exp_d      = 2'd1;
            end
          end
          default: begin
            if (pos == exp_q) begin
              digit_d[pos] = dig;
              if (exp_q == 2'd3) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                exp_d = exp_q + 2'd1;
              end
            end else if (pos == exp_q - 2'd1) begin
              digit_d[pos] = dig;
            end else begin
              frame_err = 1'b1;
              if (pos == 2'd0) begin
                digit_d[0] = dig;
                exp_d      = 2'd1;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        endcase
      end
    end
  end

  // Output stage: binary conversion, range check, valid/error pulses and timeout counter.
  always_comb begin
    min_calc  = {3'b000, digit_q[0]} * 7'd10 + {3'b000, digit_q[1]};
    sec_calc  = {3'b000, digit_q[2]} * 7'd10 + {3'b000, digit_q[3]};
    range_err = done_q && (min_calc > 7'd63 || sec_calc > 7'd63);
    valid_d   = done_q && !range_err;
    err_d     = frame_err || range_err;
    min_d     = valid_d ? min_calc[5:0] : min_q;
    sec_d     = valid_d ? sec_calc[5:0] : sec_q;
    if (valid_d)              tmo_d = '0;
    else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
    else                       tmo_d = tmo_q + TCW'(1);
  end

  // State registers with synchronous reset; a reset mid-frame drops any partial digits.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      sample_q <= 11'h7FF;
      stab_q   <= '0;
      accept_q <= 1'b0;
      state_q  <= S_IDLE;
      exp_q    <= 2'd1;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
      done_q   <= 1'b0;
      min_q    <= '0;
      sec_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      sample_q <= sample_d;
      stab_q   <= stab_d;
      accept_q <= accept_d;
      state_q  <= state_d;
      exp_q    <= exp_d;
      digit_q  <= digit_d;
      done_q   <= done_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign min_o   = min_q;
  assign sec_o   = sec_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign stale_o = (tmo_q == TMO_MAX);

`ifdef SSD_CAPTURE_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Error counter: +1 per err_o pulse, saturating, cleared only by reset.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule
